datacache_control: RTL and testbench
====================================

DATACACHE_CONTROL -- requirements
Module: datacache_control

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_read  in  1  CPU read request; held until mem_resp
- mem_write  in  1  CPU write request; held until mem_resp
- mem_resp  out  1  one-cycle CPU completion pulse
- pmem_read  out  1  line-fill request to memory; held until pmem_resp
- pmem_write  out  1  line-writeback request to memory; held until pmem_resp
- pmem_resp  in  1  memory completion pulse; fill data is valid in the same cycle
- HIT  in  1  tag match from the datapath
- way_hit  in  1  matching way
- lru_data  in  1  LRU (victim) way of the current set
- valid_out  in  2  per-way valid bits
- dirty_out  in  2  per-way dirty bits
- W_CACHE_STATUS  out  3  datapath mode: 000 idle, 100 CPU write, 001 writeback, 011 fill-read, 111 fill-commit
- LD_VALID, LD_TAG  out  2  per-way load strobes
- valid_in  out  1  valid write value
- LD_DIRTY_in  out  2  per-way dirty load; the datapath registers it by one cycle
- dirty_in_value  out  1  dirty write value
- LD_LRU_in, lru_in_value  out  1 each  LRU load strobe and value; the datapath registers them by one cycle

Function
REQ-002 SHALL implement FSM states IDLE, CHECK, WRITEBACK, FILL, COMMIT; all outputs SHALL be 0 unless stated for a state.
REQ-003 IDLE: if mem_read or mem_write, go to CHECK next cycle; otherwise stay in IDLE. pmem_resp in IDLE SHALL be ignored.
REQ-004 CHECK, read hit: mem_resp=1, LD_LRU_in=1, lru_in_value=~way_hit, then IDLE. Hit latency is 2 cycles from request.
REQ-005 CHECK, write hit: W_CACHE_STATUS=100, mem_resp=1, LD_DIRTY_in[way_hit]=1, dirty_in_value=1, LD_LRU_in=1, lru_in_value=~way_hit, then IDLE.
REQ-006 CHECK, miss: if valid_out[lru_data] and dirty_out[lru_data], go to WRITEBACK; otherwise go to FILL.
REQ-007 WRITEBACK: W_CACHE_STATUS=001 and pmem_write=1 every cycle. On pmem_resp: LD_DIRTY_in[lru_data]=1, dirty_in_value=0, then FILL.
REQ-008 FILL, before pmem_resp: W_CACHE_STATUS=011 and pmem_read=1.
REQ-009 FILL, in the pmem_resp cycle: W_CACHE_STATUS=111, pmem_read=1, LD_TAG[lru_data]=1, LD_VALID[lru_data]=1, valid_in=1, LD_DIRTY_in[lru_data]=1, dirty_in_value=0, then COMMIT.
REQ-010 COMMIT: all outputs 0 for one cycle, so the registered data-array write lands; then CHECK, which re-evaluates and SHALL hit.
REQ-011 If mem_read and mem_write are both asserted, the request SHALL be treated as a write.
REQ-012 mem_resp SHALL be asserted for exactly one cycle per request and never outside CHECK.
REQ-013 pmem_read and pmem_write SHALL never be asserted in the same cycle.
REQ-014 Way select SHALL use lru_data sampled in the same cycle; lru_data is stable during a miss because no LRU load occurs until the hit.

Reset
REQ-015 When rst=1 at a clk edge, the FSM SHALL go to IDLE and all outputs SHALL be 0 the following cycle, including mid-WRITEBACK or mid-FILL. Any pending memory transaction is abandoned.
REQ-016 After reset deassertion, the first request SHALL be accepted in the first IDLE cycle.

Configuration
REQ-017 With macro DCACHE_PERF_CNT_EN defined, SHALL add outputs hit_count[31:0] and miss_count[31:0]:
- hit_count increments on each CHECK hit; miss_count increments on each CHECK miss, excluding the post-COMMIT re-check.
- Both are cleared by rst and wrap at 2^32.
REQ-018 Without DCACHE_PERF_CNT_EN, these ports and counters SHALL NOT exist; all other behaviour is identical.

Verification
REQ-019 Read hit: mem_read=1 with HIT=1, way_hit=1 -> mem_resp at cycle 2, LD_LRU_in=1, lru_in_value=0, no pmem activity.
REQ-020 Write hit: mem_write=1 with HIT=1, way_hit=0 -> in the mem_resp cycle, W_CACHE_STATUS=100, LD_DIRTY_in=01, dirty_in_value=1.
REQ-021 Clean miss: HIT=0, lru_data=1, dirty_out=00, pmem_resp after 5 cycles -> W_CACHE_STATUS 011 for 5 cycles, then 111 with LD_TAG=10, LD_VALID=10, then a COMMIT cycle, then mem_resp once HIT=1.
REQ-022 Dirty miss: HIT=0, lru_data=0, valid_out=01, dirty_out=01 -> pmem_write with W_CACHE_STATUS=001 until pmem_resp, LD_DIRTY_in=01 with dirty_in_value=0, then the fill sequence of REQ-021.
REQ-023 Reset mid-FILL: rst=1 while pmem_read=1 -> next cycle pmem_read=0, state IDLE; a late pmem_resp SHALL be ignored.
REQ-024 With DCACHE_PERF_CNT_EN: 3 read hits plus 1 clean miss -> hit_count=4 (including the post-fill hit) and miss_count=1.

Source files
------------

// File: rtl/datacache_control.sv
// datacache_control
//
// Purpose: control FSM for a 2-way set-associative data cache. It sequences
// CPU hits, dirty-victim writebacks, line fills and the post-fill re-check,
// and drives the datapath load strobes and mode select.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   mem_read/mem_write  CPU request, held until mem_resp (both high = write)
//   mem_resp            one-cycle CPU completion pulse
//   pmem_read/write     memory fill / writeback request, held until pmem_resp
//   pmem_resp           memory completion pulse (fill data valid same cycle)
//   HIT, way_hit        tag match and matching way from the datapath
//   lru_data            victim way of the current set
//   valid_out/dirty_out per-way valid and dirty bits of the current set
//   W_CACHE_STATUS      datapath mode: 000 idle, 100 CPU write, 001 writeback,
//                       011 fill-read, 111 fill-commit
//   LD_VALID, LD_TAG    per-way load strobes, valid_in is the valid value
//   LD_DIRTY_in         per-way dirty load, dirty_in_value is the value
//   LD_LRU_in           LRU load strobe, lru_in_value is the value
//
// Optional feature: define DCACHE_PERF_CNT_EN to add hit_count/miss_count
// (32-bit, wrapping, cleared by rst).

module datacache_control (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_read,
  input  logic       mem_write,
  output logic       mem_resp,
  output logic       pmem_read,
  output logic       pmem_write,
  input  logic       pmem_resp,
  input  logic       HIT,
  input  logic       way_hit,
  input  logic       lru_data,
  input  logic [1:0] valid_out,
  input  logic [1:0] dirty_out,
  output logic [2:0] W_CACHE_STATUS,
  output logic [1:0] LD_VALID,
  output logic [1:0] LD_TAG,
  output logic       valid_in,
  output logic [1:0] LD_DIRTY_in,
  output logic       dirty_in_value,
  output logic       LD_LRU_in,
  output logic       lru_in_value
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WRITEBACK,
    FILL,
    COMMIT
  } state_t;

  state_t state_q, state_d;

  logic [1:0] lruOneHot;
  logic [1:0] hitOneHot;
  logic       victimDirty;

  assign lruOneHot   = lru_data ? 2'b10 : 2'b01;
  assign hitOneHot   = way_hit  ? 2'b10 : 2'b01;
  assign victimDirty = valid_out[lru_data] & dirty_out[lru_data];

  // State register. Reset abandons any memory transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and outputs. Outputs are decoded combinationally because the
  // hit response and the fill commit must react to HIT and pmem_resp in the
  // very cycle they arrive; the datapath registers the dirty/LRU loads itself.
  always_comb begin
    state_d        = state_q;
    mem_resp       = 1'b0;
    pmem_read      = 1'b0;
    pmem_write     = 1'b0;
    W_CACHE_STATUS = 3'b000;
    LD_VALID       = 2'b00;
    LD_TAG         = 2'b00;
    valid_in       = 1'b0;
    LD_DIRTY_in    = 2'b00;
    dirty_in_value = 1'b0;
    LD_LRU_in      = 1'b0;
    lru_in_value   = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (HIT) begin
          mem_resp     = 1'b1;
          LD_LRU_in    = 1'b1;
          lru_in_value = ~way_hit;
          // A simultaneous read+write request is handled as a write.
          if (mem_write) begin
            W_CACHE_STATUS = 3'b100;
            LD_DIRTY_in    = hitOneHot;
            dirty_in_value = 1'b1;
          end
          state_d = IDLE;
        end else if (victimDirty) begin
          state_d = WRITEBACK;
        end else begin
          state_d = FILL;
        end
      end

      WRITEBACK: begin
        W_CACHE_STATUS = 3'b001;
        pmem_write     = 1'b1;
        if (pmem_resp) begin
          LD_DIRTY_in = lruOneHot;
          state_d     = FILL;
        end
      end

      FILL: begin
        pmem_read      = 1'b1;
        W_CACHE_STATUS = 3'b011;
        if (pmem_resp) begin
          W_CACHE_STATUS = 3'b111;
          LD_TAG         = lruOneHot;
          LD_VALID       = lruOneHot;
          valid_in       = 1'b1;
          LD_DIRTY_in    = lruOneHot;
          state_d        = COMMIT;
        end
      end

      // Quiet cycle so the registered data-array write lands before the
      // re-check, which is then guaranteed to hit.
      COMMIT: begin
        state_d = CHECK;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hitCount_q;
  logic [31:0] missCount_q;
  logic        recheck_q;

  // recheck_q marks the CHECK that follows COMMIT so that it is never
  // counted as a miss; its hit is counted like any other.
  always_ff @(posedge clk) begin
    if (rst) begin
      hitCount_q  <= 32'd0;
      missCount_q <= 32'd0;
      recheck_q   <= 1'b0;
    end else begin
      if (state_q == CHECK) begin
        if (HIT) begin
          hitCount_q <= hitCount_q + 32'd1;
        end else if (!recheck_q) begin
          missCount_q <= missCount_q + 32'd1;
        end
      end
      recheck_q <= (state_q == COMMIT);
    end
  end

  assign hit_count  = hitCount_q;
  assign miss_count = missCount_q;
`endif

endmodule

// File: tb/tb_datacache_control.sv
// tb_datacache_control
//
// Self-checking bench for datacache_control. A transaction-level model turns
// each CPU request (hit/miss, victim state, memory latencies) into the list
// of per-cycle inputs and expected outputs; the tests replay these lists and
// compare the DUT outputs every cycle. Define DCACHE_PERF_CNT_EN to also
// check the performance counters.

module tb_datacache_control;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_read, mem_write, pmem_resp;
  logic       HIT, way_hit, lru_data;
  logic [1:0] valid_out, dirty_out;
  logic       mem_resp, pmem_read, pmem_write;
  logic [2:0] W_CACHE_STATUS;
  logic [1:0] LD_VALID, LD_TAG, LD_DIRTY_in;
  logic       valid_in, dirty_in_value, LD_LRU_in, lru_in_value;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count;
`endif

  int compared   = 0;
  int mismatched = 0;
  int expHits    = 0;
  int expMisses  = 0;

  // One simulated cycle: inputs to drive and the outputs they must produce.
  typedef struct {
    bit          rd, wr, resp, hit, way, lru;
    bit [1:0]    v, d;
    logic [15:0] exp;
  } cyc_t;

  cyc_t q[$];

  datacache_control dut (
    .clk            (clk),
    .rst            (rst),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_resp       (mem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_resp      (pmem_resp),
    .HIT            (HIT),
    .way_hit        (way_hit),
    .lru_data       (lru_data),
    .valid_out      (valid_out),
    .dirty_out      (dirty_out),
    .W_CACHE_STATUS (W_CACHE_STATUS),
    .LD_VALID       (LD_VALID),
    .LD_TAG         (LD_TAG),
    .valid_in       (valid_in),
    .LD_DIRTY_in    (LD_DIRTY_in),
    .dirty_in_value (dirty_in_value),
    .LD_LRU_in      (LD_LRU_in),
    .lru_in_value   (lru_in_value)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count)
`endif
  );

  always #5 clk = ~clk;

  wire [15:0] obsOut = {mem_resp, pmem_read, pmem_write, W_CACHE_STATUS,
                        LD_VALID, LD_TAG, valid_in, LD_DIRTY_in,
                        dirty_in_value, LD_LRU_in, lru_in_value};

  function automatic logic [15:0] mkOut(bit resp, bit pr, bit pw, bit [2:0] st,
                                        bit [1:0] ldv, bit [1:0] ldt, bit vi,
                                        bit [1:0] ldd, bit dv, bit ldl, bit lv);
    return {resp, pr, pw, st, ldv, ldt, vi, ldd, dv, ldl, lv};
  endfunction

  function automatic void pushCyc(bit rd, bit wr, bit resp, bit hit, bit way,
                                  bit lru, bit [1:0] v, bit [1:0] d,
                                  logic [15:0] exp);
    cyc_t c;
    c.rd = rd; c.wr = wr; c.resp = resp; c.hit = hit; c.way = way;
    c.lru = lru; c.v = v; c.d = d; c.exp = exp;
    q.push_back(c);
  endfunction

  // Expected response of a hit: LRU points away from the used way; a write
  // also marks the used way dirty and selects CPU-write mode.
  function automatic logic [15:0] hitOut(bit isWr, bit way);
    bit [1:0] wayMask = 2'b01 << way;
    return mkOut(1'b1, 1'b0, 1'b0, isWr ? 3'b100 : 3'b000, 2'b00, 2'b00, 1'b0,
                 isWr ? wayMask : 2'b00, isWr, 1'b1, !way);
  endfunction

  // Reference model: one CPU request expanded into its cycle-by-cycle story.
  function automatic void buildTxn(bit rd, bit wr, bit hitFirst, bit wayIn,
                                   bit lru, bit [1:0] v, bit [1:0] d,
                                   int wbLat, int fillLat);
    bit [1:0] victim = 2'b01 << lru;
    // Request seen in IDLE; memory noise here must be ignored.
    pushCyc(rd, wr, 1'($urandom), 1'($urandom), 1'($urandom), lru, v, d, '0);
    if (hitFirst) begin
      pushCyc(rd, wr, 1'b0, 1'b1, wayIn, lru, v, d, hitOut(wr, wayIn));
      expHits++;
      return;
    end
    expMisses++;
    pushCyc(rd, wr, 1'b0, 1'b0, 1'($urandom), lru, v, d, '0);
    if (v[lru] && d[lru]) begin
      for (int i = 0; i < wbLat; i++)
        pushCyc(rd, wr, 1'b0, 1'($urandom), 1'($urandom), lru, v, d,
                mkOut(0, 0, 1, 3'b001, 0, 0, 0, 0, 0, 0, 0));
      pushCyc(rd, wr, 1'b1, 1'($urandom), 1'($urandom), lru, v, d,
              mkOut(0, 0, 1, 3'b001, 0, 0, 0, victim, 0, 0, 0));
    end
    for (int i = 0; i < fillLat; i++)
      pushCyc(rd, wr, 1'b0, 1'($urandom), 1'($urandom), lru, v, d,
              mkOut(0, 1, 0, 3'b011, 0, 0, 0, 0, 0, 0, 0));
    pushCyc(rd, wr, 1'b1, 1'($urandom), 1'($urandom), lru, v, d,
            mkOut(0, 1, 0, 3'b111, victim, victim, 1, victim, 0, 0, 0));
    pushCyc(rd, wr, 1'b0, 1'($urandom), 1'($urandom), lru, v, d, '0);
    pushCyc(rd, wr, 1'b0, 1'b1, lru, lru, v, d, hitOut(wr, lru));
    expHits++;
  endfunction

  function automatic void pushIdle(int n);
    for (int i = 0; i < n; i++)
      pushCyc(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 2'($urandom), 2'($urandom), '0);
  endfunction

  // Drive the next queued cycle just after the clock edge and let it settle.
  task automatic applyStimulus(output logic [15:0] exp);
    cyc_t c;
    c = q.pop_front();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mem_read  = c.rd;
    mem_write = c.wr;
    pmem_resp = c.resp;
    HIT       = c.hit;
    way_hit   = c.way;
    lru_data  = c.lru;
    valid_out = c.v;
    dirty_out = c.d;
    exp       = c.exp;
    #3;
  endtask

  // Holds rst for one edge; the following applyStimulus releases it.
  task automatic pulseReset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    pmem_resp = 1'b0;
    expHits   = 0;
    expMisses = 0;
  endtask

  task automatic test_reset();
    logic [15:0] e;
    int n = 0;
    pulseReset();
    pmem_resp = 1'b1;
    @(posedge clk);
    #1;
    mem_read = 1'b1;
    #3;
    compared++;
    if (obsOut !== 16'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", obsOut, 16'h0);
    end
`ifdef DCACHE_PERF_CNT_EN
    compared++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0",
               hit_count, miss_count);
    end
`endif
    // First request is taken in the first IDLE cycle after release.
    buildTxn(1, 0, 1, 1, 0, 2'b11, 2'b00, 0, 0);
    pushIdle(1);
    while (q.size() > 0) begin
      applyStimulus(e);
      compared++;
      if (obsOut !== e) begin
        mismatched++;
        $display("[TB] FAIL reset_first_req cycle %0d: got %h expected %h", n, obsOut, e);
      end
      n++;
    end
  endtask

  task automatic test_directed();
    logic [15:0] e;
    int n = 0;
    buildTxn(1, 0, 1, 1, 0, 2'b11, 2'b00, 0, 0);  // read hit, way 1
    buildTxn(0, 1, 1, 0, 1, 2'b11, 2'b00, 0, 0);  // write hit, way 0
    pushIdle(2);
    buildTxn(1, 0, 0, 0, 1, 2'b11, 2'b00, 0, 5);  // clean miss, victim 1
    pushIdle(1);
    buildTxn(1, 0, 0, 1, 0, 2'b01, 2'b01, 3, 2);  // dirty miss, victim 0
    buildTxn(1, 1, 1, 1, 0, 2'b00, 2'b00, 0, 0);  // read+write counts as write
    pushIdle(1);
    while (q.size() > 0) begin
      applyStimulus(e);
      compared++;
      if (obsOut !== e) begin
        mismatched++;
        $display("[TB] FAIL directed cycle %0d: got %h expected %h", n, obsOut, e);
      end
      n++;
    end
  endtask

  task automatic test_idle_pmem_resp();
    logic [15:0] e;
    int n = 0;
    for (int i = 0; i < 6; i++)
      pushCyc(0, 0, 1, 1'($urandom), 1'($urandom), 1'($urandom), 2'b11, 2'b11, '0);
    buildTxn(0, 1, 0, 0, 0, 2'b11, 2'b11, 1, 1);
    pushIdle(1);
    while (q.size() > 0) begin
      applyStimulus(e);
      compared++;
      if (obsOut !== e) begin
        mismatched++;
        $display("[TB] FAIL idle_pmem_resp cycle %0d: got %h expected %h", n, obsOut, e);
      end
      n++;
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [15:0] e;
    int n = 0;
    buildTxn(1, 0, 0, 0, 0, 2'b10, 2'b00, 0, 6);
    // IDLE, CHECK, then two FILL cycles with pmem_read high.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(e);
      compared++;
      if (obsOut !== e) begin
        mismatched++;
        $display("[TB] FAIL fill_before_reset cycle %0d: got %h expected %h", i, obsOut, e);
      end
    end
    rst = 1'b1;
    q.delete();
    // Late memory response after the reset must be ignored.
    pushCyc(0, 0, 1, 0, 0, 0, 2'b10, 2'b00, '0);
    pushCyc(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, '0);
    buildTxn(1, 0, 1, 0, 1, 2'b11, 2'b00, 0, 0);
    pushIdle(1);
    while (q.size() > 0) begin
      applyStimulus(e);
      compared++;
      if (obsOut !== e) begin
        mismatched++;
        $display("[TB] FAIL reset_mid_fill cycle %0d: got %h expected %h", n, obsOut, e);
      end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    int n = 0;
    int kind;
    pulseReset();
    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 2));
      buildTxn(kind != 1, kind != 0, 1'($urandom), 1'($urandom), 1'($urandom),
               2'($urandom), 2'($urandom), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 4)));
      pushIdle(int'($urandom_range(0, 2)));
    end
    pushIdle(1);
    while (q.size() > 0) begin
      applyStimulus(e);
      compared++;
      if (obsOut !== e) begin
        mismatched++;
        $display("[TB] FAIL random_traffic cycle %0d: got %h expected %h", n, obsOut, e);
      end
      n++;
    end
`ifdef DCACHE_PERF_CNT_EN
    compared++;
    if (hit_count !== 32'(expHits) || miss_count !== 32'(expMisses)) begin
      mismatched++;
      $display("[TB] FAIL random_counters: got %0d/%0d expected %0d/%0d",
               hit_count, miss_count, expHits, expMisses);
    end
`endif
  endtask

`ifdef DCACHE_PERF_CNT_EN
  task automatic test_perf_counters();
    logic [15:0] e;
    pulseReset();
    for (int i = 0; i < 3; i++) begin
      buildTxn(1, 0, 1, 1'(i), 0, 2'b11, 2'b00, 0, 0);
      pushIdle(1);
    end
    buildTxn(1, 0, 0, 0, 1, 2'b11, 2'b00, 0, 2);
    pushIdle(1);
    while (q.size() > 0) applyStimulus(e);
    compared++;
    if (hit_count !== 32'd4) begin
      mismatched++;
      $display("[TB] FAIL perf_hits: got %0d expected 4", hit_count);
    end
    compared++;
    if (miss_count !== 32'd1) begin
      mismatched++;
      $display("[TB] FAIL perf_misses: got %0d expected 1", miss_count);
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    pmem_resp = 1'b0;
    HIT       = 1'b0;
    way_hit   = 1'b0;
    lru_data  = 1'b0;
    valid_out = 2'b00;
    dirty_out = 2'b00;
    test_reset();
    test_directed();
    test_idle_pmem_resp();
    test_reset_mid_fill();
`ifdef DCACHE_PERF_CNT_EN
    test_perf_counters();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
